lfsr_prng: RTL

Parametrised Fibonacci LFSR pseudo-random generator with runtime-programmable tap polynomial, seed loading, K-bit-per-cycle unrolled stepping and a valid/ready output stream. It is the next-generation random source for masking and noise injection in the cipher cores. A warm-up phase discards the first steps after every seed load. Zero-state lockup is detected and recovered automatically.

---
 rtl/lfsr_pkg.sv | 29 ++
 rtl/lfsr_step_k.sv | 32 +++
 rtl/lfsr_prng.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the lfsr_prng random source: FSM encoding,
// counter widths and default tap polynomials per state width.
package lfsr_pkg;

  localparam int MAX_N    = 64;
  localparam int CNT_W    = 8;
  localparam int PERIOD_W = 32;

  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } fsm_t;

  localparam logic [3:0]  POLY_4  = 4'h9;
  localparam logic [7:0]  POLY_8  = 8'hB8;
  localparam logic [15:0] POLY_16 = 16'hD008;
  localparam logic [31:0] POLY_32 = 32'h80200003;

  // Widths without a listed polynomial fall back to the 16-bit mask.
  function automatic logic [MAX_N-1:0] default_poly(input int n);
    case (n)
      4:       return MAX_N'(POLY_4);
      8:       return MAX_N'(POLY_8);
      32:      return MAX_N'(POLY_32);
      default: return MAX_N'(POLY_16);
    endcase
  endfunction

endpackage

// File: rtl/lfsr_step_k.sv
// Combinational K-step unroll of a Fibonacci LFSR: shifts left, feedback
// enters at bit 0, oldest feedback bit reported in the MSB of fb_bits.
module lfsr_step_k #(
  parameter int N = 16,
  parameter int K = 1
) (
  input  logic [N-1:0] state,
  input  logic [N-1:0] taps,
  output logic [N-1:0] next_state,
  output logic [K-1:0] fb_bits
);

  logic [N-1:0] s;
  logic [K-1:0] bits;
  logic         fb;

  // NOTE: blocking assignments here build a chain of K combinational stages;
  // each iteration sees the value the previous iteration produced.
  always_comb begin
    s    = state;
    bits = '0;
    fb   = 1'b0;
    for (int i = 0; i < K; i++) begin
      fb            = ^(s & taps);
      bits[K-1-i]   = fb;
      s             = {s[N-2:0], fb};
    end
    next_state = s;
    fb_bits    = bits;
  end

endmodule

// File: rtl/lfsr_prng.sv
// Fibonacci LFSR random source with programmable taps, seed load, warm-up
// and zero-state recovery. Define LFSR_PERIOD_CNT_EN to add period/period_hit.
module lfsr_prng
  import lfsr_pkg::*;
#(
  parameter int           N            = 16,
  parameter int           K            = 1,
  parameter logic [N-1:0] DEFAULT_POLY = N'(default_poly(N)),
  parameter logic [N-1:0] DEFAULT_SEED = N'(1),
  parameter int           WARMUP       = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         seed_load,
  input  logic [N-1:0] seed,
  input  logic         poly_load,
  input  logic [N-1:0] poly,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [N-1:0] random,
  output logic [K-1:0] rnd_bits,
  output logic         lockup,
  output logic         busy
`ifdef LFSR_PERIOD_CNT_EN
  ,
  output logic [PERIOD_W-1:0] period,
  output logic                period_hit
`endif
);

  localparam logic [CNT_W-1:0] WARM_CNT = CNT_W'(WARMUP);
  localparam logic [CNT_W-1:0] K_CNT    = CNT_W'(K);
  localparam fsm_t             START_ST = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
  localparam logic [N-1:0]     ONE      = N'(1);

  fsm_t             fsm_q, fsm_d;
  logic [N-1:0]     state_q, state_d;
  logic [N-1:0]     taps_q;
  logic [N-1:0]     step_next;
  logic [K-1:0]     step_bits;
  logic [K-1:0]     rnd_q, rnd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lockup_q, lockup_d;
  logic             zero_state;
  logic             advance;

  lfsr_step_k #(
    .N (N),
    .K (K)
  ) u_step (
    .state      (state_q),
    .taps       (taps_q),
    .next_state (step_next),
    .fb_bits    (step_bits)
  );

  assign zero_state = (state_q == '0);
  assign out_valid  = (fsm_q == ST_RUN);
  assign busy       = (fsm_q == ST_WARMUP);
  assign random     = state_q;
  assign rnd_bits   = rnd_q;
  assign lockup     = lockup_q;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/case leaves a variable unassigned and infers a latch.
  always_comb begin
    fsm_d    = fsm_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    rnd_d    = rnd_q;
    lockup_d = lockup_q;
    advance  = 1'b0;

    if (seed_load) begin
      state_d  = seed;
      fsm_d    = START_ST;
      cnt_d    = WARM_CNT;
      lockup_d = 1'b0;
    end else if (ena) begin
      if (zero_state) begin
        // Recovery cycle: not an advance, so the warm-up count is untouched.
        state_d  = ONE;
        lockup_d = 1'b1;
      end else begin
        case (fsm_q)
          ST_WARMUP: begin
            advance = 1'b1;
            cnt_d   = (cnt_q > K_CNT) ? cnt_q - K_CNT : '0;
            if (cnt_d == '0) fsm_d = ST_RUN;
          end
          ST_RUN: advance = out_ready;
          default: fsm_d = START_ST;
        endcase
        if (advance) begin
          state_d = step_next;
          rnd_d   = step_bits;
        end
      end
    end
  end

  // NOTE: state uses non-blocking assignments so all registers update from
  // the same pre-edge values; rst is asynchronous and overrides everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q    <= START_ST;
      cnt_q    <= WARM_CNT;
      state_q  <= DEFAULT_SEED;
      rnd_q    <= '0;
      lockup_q <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      rnd_q    <= rnd_d;
      lockup_q <= lockup_d;
    end
  end

  // Taps change independently of ena; an advance in the same cycle still
  // sees the old mask because step_next is computed from taps_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            taps_q <= DEFAULT_POLY;
    else if (poly_load) taps_q <= poly;
  end

`ifdef LFSR_PERIOD_CNT_EN
  localparam logic [PERIOD_W-1:0] K_STEPS = PERIOD_W'(K);

  logic [PERIOD_W-1:0] step_cnt_q;
  logic [PERIOD_W-1:0] period_q;
  logic [N-1:0]        seed_q;
  logic                hit_q;
  logic                measured_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt_q <= '0;
      period_q   <= '0;
      seed_q     <= DEFAULT_SEED;
      hit_q      <= 1'b0;
      measured_q <= 1'b0;
    end else begin
      hit_q <= 1'b0;
      if (seed_load) begin
        step_cnt_q <= '0;
        period_q   <= '0;
        seed_q     <= seed;
        measured_q <= 1'b0;
      end else if (advance) begin
        step_cnt_q <= step_cnt_q + K_STEPS;
        if (step_next == seed_q) begin
          hit_q <= 1'b1;
          // First return to the seed is the period; later hits keep it.
          if (!measured_q) begin
            period_q   <= step_cnt_q + K_STEPS;
            measured_q <= 1'b1;
          end
        end
      end
    end
  end

  assign period     = period_q;
  assign period_hit = hit_q;
`endif

endmodule
